// File: rtl/tx_pkt_seq_pkg.sv
// Shared states and timing constants for the TX packet sequencer.
package tx_pkt_seq_pkg;

  localparam int unsigned BIDX_W     = 7;
  localparam int unsigned WDOG_W     = 12;
  localparam int unsigned AC_LEN     = 72;
  localparam int unsigned AC_LEN_ID  = 68;
  localparam int unsigned HDR_LEN    = 54;
  localparam int unsigned PY_WDOG_US = 2745;

  typedef enum logic [2:0] {
    IDLE,
    AC,
    HDR,
    PY_ARM,
    PY_RUN
  } tx_state_e;

  // Last access-code bit index; ID packets carry a shortened access code.
  function automatic logic [BIDX_W-1:0] last_ac_idx(input logic id);
    return id ? BIDX_W'(AC_LEN_ID - 1) : BIDX_W'(AC_LEN - 1);
  endfunction

endpackage

// File: rtl/tx_pkt_seq_wdog.sv
// Payload watchdog: counts microseconds spent in PY_RUN and flags expiry once.
// Only built when TX_PKT_SEQ_WDOG_EN is defined.
module tx_pkt_seq_wdog
  import tx_pkt_seq_pkg::*;
(
  input  logic clk_6M,
  input  logic rstz,
  input  logic clr,
  input  logic inc,
  output logic expire_p
);

  logic [WDOG_W-1:0] cnt;

  // Counter saturates so a stuck inc can never re-trigger expiry by wrapping.
  always_ff @(posedge clk_6M or negedge rstz) begin
    if (!rstz) begin
      cnt      <= '0;
      expire_p <= 1'b0;
    end else begin
      expire_p <= 1'b0;
      if (clr) begin
        cnt <= '0;
      end else if (inc) begin
        if (cnt == WDOG_W'(PY_WDOG_US - 1)) expire_p <= 1'b1;
        if (cnt != '1) cnt <= cnt + WDOG_W'(1);
      end
    end
  end

endmodule

// File: rtl/tx_pkt_seq.sv
// TX packet sequencer: steps access code, header and payload phases of a packet.
// Define TX_PKT_SEQ_WDOG_EN to add the payload watchdog (tx_err_p); otherwise tx_err_p stays 0.
module tx_pkt_seq
  import tx_pkt_seq_pkg::*;
(
  input  logic              clk_6M,
  input  logic              rstz,
  input  logic              p_1us,
  input  logic              tx_start_p,
  input  logic              tx_abort,
  input  logic              id_pkt,
  input  logic              py_period,
  output logic              tx_busy,
  output logic              ac_en,
  output logic              hdr_en,
  output logic [BIDX_W-1:0] hdr_bitidx,
  output logic              bit_p,
  output logic              py_st_p,
  output logic              py_datvalid_p,
  output logic              tx_done_p,
  output logic              tx_err_p
);

  tx_state_e         state, state_nxt;
  logic              id_q, id_nxt;
  logic [BIDX_W-1:0] bitidx_nxt;
  logic              done_nxt, err_nxt;
  logic              wdog_exp;

`ifdef TX_PKT_SEQ_WDOG_EN
  logic wdog_clr, wdog_inc;

  assign wdog_clr = (state_nxt == PY_ARM);
  assign wdog_inc = (state == PY_RUN) && p_1us;

  tx_pkt_seq_wdog u_wdog (
    .clk_6M   (clk_6M),
    .rstz     (rstz),
    .clr      (wdog_clr),
    .inc      (wdog_inc),
    .expire_p (wdog_exp)
  );
`else
  assign wdog_exp = 1'b0;
`endif

  always_ff @(posedge clk_6M or negedge rstz) begin
    if (!rstz) begin
      state      <= IDLE;
      id_q       <= 1'b0;
      hdr_bitidx <= '0;
      tx_busy    <= 1'b0;
      ac_en      <= 1'b0;
      hdr_en     <= 1'b0;
      tx_done_p  <= 1'b0;
      tx_err_p   <= 1'b0;
    end else begin
      state      <= state_nxt;
      id_q       <= id_nxt;
      hdr_bitidx <= bitidx_nxt;
      tx_busy    <= (state_nxt != IDLE);
      ac_en      <= (state_nxt == AC);
      hdr_en     <= (state_nxt == HDR);
      tx_done_p  <= done_nxt;
      tx_err_p   <= err_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    id_nxt        = id_q;
    bitidx_nxt    = hdr_bitidx;
    done_nxt      = 1'b0;
    err_nxt       = 1'b0;
    bit_p         = 1'b0;
    py_st_p       = 1'b0;
    py_datvalid_p = 1'b0;

    case (state)
      IDLE: begin
        bitidx_nxt = '0;
        if (tx_start_p) begin
          state_nxt = AC;
          id_nxt    = id_pkt;
        end
      end
      AC: begin
        bit_p = p_1us;
        if (p_1us) begin
          if (hdr_bitidx == last_ac_idx(id_q)) begin
            bitidx_nxt = '0;
            if (id_q) begin
              state_nxt = IDLE;
              done_nxt  = 1'b1;
            end else begin
              state_nxt = HDR;
            end
          end else begin
            bitidx_nxt = hdr_bitidx + BIDX_W'(1);
          end
        end
      end
      HDR: begin
        bit_p = p_1us;
        if (p_1us) begin
          if (hdr_bitidx == BIDX_W'(HDR_LEN - 1)) begin
            bitidx_nxt = '0;
            state_nxt  = PY_ARM;
            py_st_p    = 1'b1;
          end else begin
            bitidx_nxt = hdr_bitidx + BIDX_W'(1);
          end
        end
      end
      PY_ARM: state_nxt = PY_RUN;
      PY_RUN: begin
        py_datvalid_p = p_1us & py_period;
        // Watchdog expiry outranks a payload end landing in the same cycle.
        if (wdog_exp) begin
          state_nxt = IDLE;
          err_nxt   = 1'b1;
        end else if (!py_period) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Abort overrides every transition and silences all strobes.
    if (tx_abort) begin
      state_nxt     = IDLE;
      bitidx_nxt    = '0;
      done_nxt      = 1'b0;
      err_nxt       = 1'b0;
      bit_p         = 1'b0;
      py_st_p       = 1'b0;
      py_datvalid_p = 1'b0;
    end
  end

endmodule
